// File: rtl/gate_prober.sv
// Stimulus/response prober for a 2-input gate: walks {A,B} through 00..11,
// samples Q after SETTLE_CYCLES idle cycles, then publishes the truth table and gate class.
// Optional feature macro: GATE_PROBER_CHANGE_EN (adds the 'changed' output).
module gate_prober #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       A,
  output logic       B,
  input  logic       Q,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth_table,
  output logic [2:0] gate_id,
  output logic       id_valid
`ifdef GATE_PROBER_CHANGE_EN
  ,
  output logic       changed
`endif
);

  localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t     state;
  logic [1:0] idx;
  logic [7:0] cnt;
  logic [3:0] shadow;
  logic [3:0] sample_tab;
  logic [2:0] new_id;
`ifdef GATE_PROBER_CHANGE_EN
  logic       published;
`endif

  // Shadow table with the current Q merged in, so the final sample edge can
  // publish the complete table in the same cycle it enters DONE.
  always_comb begin
    sample_tab      = shadow;
    sample_tab[idx] = Q;
  end

  always_comb begin
    new_id = 3'd7;
    case (sample_tab)
      4'b1000: new_id = 3'd0;
      4'b1110: new_id = 3'd1;
      4'b0111: new_id = 3'd2;
      4'b0001: new_id = 3'd3;
      4'b0110: new_id = 3'd4;
      4'b1001: new_id = 3'd5;
      default: new_id = 3'd7;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      A           <= 1'b0;
      B           <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      truth_table <= '0;
      gate_id     <= 3'd7;
      id_valid    <= 1'b0;
      idx         <= '0;
      cnt         <= '0;
      shadow      <= '0;
`ifdef GATE_PROBER_CHANGE_EN
      changed     <= 1'b0;
      published   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            A      <= 1'b0;
            B      <= 1'b0;
            idx    <= '0;
            cnt    <= SETTLE;
            shadow <= '0;
            busy   <= 1'b1;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            shadow <= sample_tab;
            if (idx == 2'd3) begin
              state       <= DONE;
              done        <= 1'b1;
              truth_table <= sample_tab;
              gate_id     <= new_id;
              id_valid    <= (new_id != 3'd7);
              A           <= 1'b0;
              B           <= 1'b0;
`ifdef GATE_PROBER_CHANGE_EN
              changed     <= published && (sample_tab != truth_table);
              published   <= 1'b1;
`endif
            end else begin
              idx    <= idx + 2'd1;
              {A, B} <= idx + 2'd1;
              cnt    <= SETTLE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
`ifdef GATE_PROBER_CHANGE_EN
          changed <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_prober.sv
// Directed, table-driven bench for gate_prober: a behavioural gate model supplies Q,
// each table row is one probe run checked for latency, A/B sequence and results.
module tb_gate_prober;

  localparam int unsigned S   = 2;
  localparam int unsigned LAT = 4 * (S + 1);

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       A, B, Q;
  logic       busy, done, id_valid;
  logic [3:0] truth_table;
  logic [2:0] gate_id;
`ifdef GATE_PROBER_CHANGE_EN
  logic       changed;
`endif

  int unsigned n_checks;
  int unsigned n_fail;

  // gate model: 0 OR, 1 NAND, 2 XOR, 3 stuck1, 4 AND, 5 NOR, 6 XNOR, 7 stuck0
  logic [2:0] mode;
  always_comb begin
    Q = 1'b0;
    case (mode)
      3'd0: Q = A | B;
      3'd1: Q = ~(A & B);
      3'd2: Q = A ^ B;
      3'd3: Q = 1'b1;
      3'd4: Q = A & B;
      3'd5: Q = ~(A | B);
      3'd6: Q = ~(A ^ B);
      default: Q = 1'b0;
    endcase
  end

  gate_prober #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Q(Q),
    .busy(busy), .done(done), .truth_table(truth_table), .gate_id(gate_id),
    .id_valid(id_valid)
`ifdef GATE_PROBER_CHANGE_EN
    , .changed(changed)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] mode;
    logic [3:0] tt;
    logic [2:0] id;
  } vec_t;

  vec_t vecs[10];

  logic [3:0] prev_tt;
  logic       have_prev;

  // One full probe run; optionally pulses start mid-run to show it is ignored.
  task automatic run_probe(input logic [2:0] m, input logic [3:0] exp_tt,
                           input logic [2:0] exp_id, input bit poke);
    int unsigned j;
    bit seen;
    mode = m;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("busy_at_accept", busy, 1'b1);
    check("ab_at_accept", {A, B}, 2'b00);
    j = 0;
    seen = 0;
    while (j < LAT + 4 && !seen) begin
      @(posedge clk); #1;
      j++;
      if (done) seen = 1;
      else begin
        check("ab_seq", {A, B}, 2'(j / (S + 1)));
        check("busy_run", busy, 1'b1);
        if (poke && (j == 4 || j == 9)) start = 1'b1;
        else start = 1'b0;
      end
    end
    start = 1'b0;
    check("done_latency", j, seen ? LAT : 32'hFFFF_FFFF);
    check("truth_table", truth_table, exp_tt);
    check("gate_id", gate_id, exp_id);
    check("id_valid", id_valid, exp_id != 3'd7);
    check("ab_done", {A, B}, 2'b00);
    check("busy_done", busy, 1'b1);
`ifdef GATE_PROBER_CHANGE_EN
    check("changed", changed, have_prev && (exp_tt != prev_tt));
`endif
    prev_tt   = exp_tt;
    have_prev = 1'b1;
    @(posedge clk); #1;
    check("done_pulse_end", done, 1'b0);
    check("busy_end", busy, 1'b0);
    check("tt_hold", truth_table, exp_tt);
`ifdef GATE_PROBER_CHANGE_EN
    check("changed_end", changed, 1'b0);
`endif
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    have_prev = 1'b0;
    prev_tt   = '0;
    mode      = 3'd0;
    start     = 1'b0;
    rst_n     = 1'b0;

    vecs[0] = '{3'd0, 4'b1110, 3'd1};
    vecs[1] = '{3'd1, 4'b0111, 3'd2};
    vecs[2] = '{3'd2, 4'b0110, 3'd4};
    vecs[3] = '{3'd3, 4'b1111, 3'd7};
    vecs[4] = '{3'd4, 4'b1000, 3'd0};
    vecs[5] = '{3'd4, 4'b1000, 3'd0};
    vecs[6] = '{3'd0, 4'b1110, 3'd1};
    vecs[7] = '{3'd5, 4'b0001, 3'd3};
    vecs[8] = '{3'd6, 4'b1001, 3'd5};
    vecs[9] = '{3'd7, 4'b0000, 3'd7};

    #12;
    check("rst_ab", {A, B}, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_tt", truth_table, 4'b0000);
    check("rst_id", gate_id, 3'd7);
    check("rst_valid", id_valid, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("idle_busy", busy, 1'b0);
    check("idle_ab", {A, B}, 2'b00);
    check("idle_done", done, 1'b0);

    for (int i = 0; i < 10; i++)
      run_probe(vecs[i].mode, vecs[i].tt, vecs[i].id, (i == 1 || i == 2));

    // abort during vector 2 (A=1,B=0)
    mode = 3'd2;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2 * (S + 1) + 1) @(posedge clk);
    #1;
    check("pre_abort_ab", {A, B}, 2'b10);
    rst_n = 1'b0;
    #1;
    check("abort_ab", {A, B}, 2'b00);
    check("abort_busy", busy, 1'b0);
    check("abort_tt", truth_table, 4'b0000);
    check("abort_id", gate_id, 3'd7);
    check("abort_valid", id_valid, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    have_prev = 1'b0;
    run_probe(3'd2, 4'b0110, 3'd4, 1'b0);
    run_probe(3'd1, 4'b0111, 3'd2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
